// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared by every inter-stage pipeline register.
//   PC_W_DEF / INSTR_W_DEF : default datapath widths
//   NOP_INSTR_DEF          : bubble instruction word (sll $0,$0,0)
//   stage_ctl_e            : per-edge action of a stage register
package pipeline_pkg;

   localparam int unsigned PC_W_DEF    = 32;
   localparam int unsigned INSTR_W_DEF = 32;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      HOLD   = 2'd1,
      BUBBLE = 2'd2
   } stage_ctl_e;

endpackage

// File: rtl/fetch_decode_stage_reg_sat_counter.sv
// sat_counter: up-counter that saturates at all-ones and never wraps.
//   clk   : rising-edge clock
//   reset : synchronous, active-high clear
//   inc   : count this cycle
//   count : current count (CNT_W bits)
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_decode_stage_reg.sv
// fetch_decode_stage_reg: IF->ID pipeline register with valid bit, stall and flush.
//   Clk, Reset (sync, active-high)
//   PCAddResult, Instruction, ValidIn : fetch slot contents
//   Stall : hold current contents; Flush : replace contents with a bubble
//   PCAddResultOut, InstructionOut, ValidOut : decode slot contents
//   StallCount, FlushCount : saturating perf counters
// Build option: define FTD_PERF_CNT_EN to implement the perf counters;
// otherwise StallCount/FlushCount are tied to zero.
module fetch_decode_stage_reg
   import pipeline_pkg::*;
#(
   parameter int unsigned  PC_W      = PC_W_DEF,
   parameter int unsigned  INSTR_W   = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
   parameter int unsigned  CNT_W     = 16
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [PC_W-1:0]    PCAddResult,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               ValidIn,
   input  logic               Stall,
   input  logic               Flush,
   output logic [PC_W-1:0]    PCAddResultOut,
   output logic [INSTR_W-1:0] InstructionOut,
   output logic               ValidOut,
   output logic [CNT_W-1:0]   StallCount,
   output logic [CNT_W-1:0]   FlushCount
);

   stage_ctl_e ctl;

   logic [PC_W-1:0]    pc_d,    pc_q;
   logic [INSTR_W-1:0] instr_d, instr_q;
   logic               valid_d, valid_q;

   // Priority: Reset > Flush > Stall > load.
   always_comb begin
      ctl = LOAD;
      if (Reset || Flush) begin
         ctl = BUBBLE;
      end else if (Stall) begin
         ctl = HOLD;
      end
   end

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      case (ctl)
         LOAD: begin
            // An invalid fetch slot keeps its PC but never exposes its instruction.
            pc_d    = PCAddResult;
            instr_d = ValidIn ? Instruction : NOP_INSTR;
            valid_d = ValidIn;
         end
         BUBBLE: begin
            pc_d    = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign PCAddResultOut = pc_q;
   assign InstructionOut = instr_q;
   assign ValidOut       = valid_q;

`ifdef FTD_PERF_CNT_EN
   logic stall_inc;
   logic flush_inc;

   // Both decisions use the pre-edge valid bit; flush wins over a
   // simultaneous stall, and a held bubble is not counted.
   assign stall_inc = Stall && !Flush && valid_q;
   assign flush_inc = Flush && valid_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (Clk),
      .reset (Reset),
      .inc   (stall_inc),
      .count (StallCount)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (Clk),
      .reset (Reset),
      .inc   (flush_inc),
      .count (FlushCount)
   );
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_stage_reg.sv
// tb_fetch_decode_stage_reg: directed scoreboard bench for fetch_decode_stage_reg.
// Two instances share all inputs: default widths (CNT_W=16) and CNT_W=2.
module tb_fetch_decode_stage_reg;

`ifdef FTD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, vin, stall, flush;
   logic [31:0] pc, ins;

   logic [31:0] pc_o, ins_o, pc_o2, ins_o2;
   logic        v_o, v_o2;
   logic [15:0] sc, fc;
   logic [1:0]  sc2, fc2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        v;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [1:0]  sc2;
      logic [1:0]  fc2;
   } exp_t;

   typedef struct packed {
      logic        rst;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        vin;
      logic        stall;
      logic        flush;
      exp_t        e;
   } vec_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   row   = 0;

   always #5 clk = ~clk;

   fetch_decode_stage_reg dut (
      .Clk(clk), .Reset(rst), .PCAddResult(pc), .Instruction(ins),
      .ValidIn(vin), .Stall(stall), .Flush(flush),
      .PCAddResultOut(pc_o), .InstructionOut(ins_o), .ValidOut(v_o),
      .StallCount(sc), .FlushCount(fc)
   );

   fetch_decode_stage_reg #(.CNT_W(2)) dut2 (
      .Clk(clk), .Reset(rst), .PCAddResult(pc), .Instruction(ins),
      .ValidIn(vin), .Stall(stall), .Flush(flush),
      .PCAddResultOut(pc_o2), .InstructionOut(ins_o2), .ValidOut(v_o2),
      .StallCount(sc2), .FlushCount(fc2)
   );

   task automatic check(input string name, input int r, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, r, act, exp);
      end
   endtask

   // Monitor: the DUT presents a new slot on every edge; compare one
   // queued expectation per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            row++;
            check("pc_out",    row, pc_o,  e.pc);
            check("instr_out", row, ins_o, e.ins);
            check("valid_out", row, {31'b0, v_o}, {31'b0, e.v});
            check("stall_cnt", row, {16'b0, sc},  {16'b0, e.sc});
            check("flush_cnt", row, {16'b0, fc},  {16'b0, e.fc});
            check("pc_out_w2",    row, pc_o2,  e.pc);
            check("valid_out_w2", row, {31'b0, v_o2}, {31'b0, e.v});
            check("stall_cnt_w2", row, {30'b0, sc2}, {30'b0, e.sc2});
            check("flush_cnt_w2", row, {30'b0, fc2}, {30'b0, e.fc2});
         end
      end
   end

   function automatic vec_t mk(input logic r, input logic [31:0] p, input logic [31:0] i,
                               input logic vi, input logic s, input logic f,
                               input logic [31:0] ep, input logic [31:0] ei, input logic ev,
                               input int esc, input int efc, input int esc2, input int efc2);
      vec_t t;
      t.rst = r; t.pc = p; t.ins = i; t.vin = vi; t.stall = s; t.flush = f;
      t.e.pc  = ep;
      t.e.ins = ei;
      t.e.v   = ev;
      t.e.sc  = PERF ? 16'(esc)  : 16'd0;
      t.e.fc  = PERF ? 16'(efc)  : 16'd0;
      t.e.sc2 = PERF ? 2'(esc2)  : 2'd0;
      t.e.fc2 = PERF ? 2'(efc2)  : 2'd0;
      return t;
   endfunction

   initial begin
      vec_t vecs[$];
      int   waited;
      rst = 1'b1; pc = '0; ins = '0; vin = 1'b0; stall = 1'b0; flush = 1'b0;

      //          rst pc          ins           vi st fl  exp pc      exp ins       v  sc fc sc2 fc2
      vecs.push_back(mk(1, 32'h4,  32'h8C010000, 1, 0, 0, 32'h0,  32'h00000000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 32'h4,  32'h8C010000, 1, 0, 0, 32'h0,  32'h00000000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 32'h8,  32'h20020005, 1, 0, 0, 32'h8,  32'h20020005, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 32'hC,  32'h11111111, 1, 1, 0, 32'h8,  32'h20020005, 1, 1, 0, 1, 0));
      vecs.push_back(mk(0, 32'h10, 32'h22222222, 1, 1, 0, 32'h8,  32'h20020005, 1, 2, 0, 2, 0));
      vecs.push_back(mk(0, 32'h14, 32'h33333333, 0, 1, 0, 32'h8,  32'h20020005, 1, 3, 0, 3, 0));
      // flush and stall together on a valid slot: flush only
      vecs.push_back(mk(0, 32'h18, 32'h44444444, 1, 1, 1, 32'h0,  32'h00000000, 0, 3, 1, 3, 1));
      // stall on a bubble: held, not counted
      vecs.push_back(mk(0, 32'h1C, 32'h55555555, 1, 1, 0, 32'h0,  32'h00000000, 0, 3, 1, 3, 1));
      // invalid fetch slot: PC captured, instruction forced to NOP
      vecs.push_back(mk(0, 32'hC,  32'hFFFFFFFF, 0, 0, 0, 32'hC,  32'h00000000, 0, 3, 1, 3, 1));
      // flush of an invalid slot: not counted
      vecs.push_back(mk(0, 32'h20, 32'h66666666, 1, 0, 1, 32'h0,  32'h00000000, 0, 3, 1, 3, 1));
      vecs.push_back(mk(0, 32'h24, 32'h77777777, 1, 0, 0, 32'h24, 32'h77777777, 1, 3, 1, 3, 1));
      // reset during a stall: everything cleared
      vecs.push_back(mk(1, 32'h28, 32'h88888888, 1, 1, 0, 32'h0,  32'h00000000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 32'h18, 32'hAABBCCDD, 1, 0, 0, 32'h18, 32'hAABBCCDD, 1, 0, 0, 0, 0));
      // six valid stall cycles: narrow counter saturates at 3
      for (int unsigned k = 1; k <= 6; k++) begin
         vecs.push_back(mk(0, 32'h100 + 32'(k), 32'hDEAD0000 + 32'(k), 1, 1, 0,
                           32'h18, 32'hAABBCCDD, 1, int'(k), 0, (k < 3) ? int'(k) : 3, 0));
      end
      vecs.push_back(mk(0, 32'h30, 32'h99999999, 1, 0, 1, 32'h0,  32'h00000000, 0, 6, 1, 3, 1));
      // reset together with flush and stall
      vecs.push_back(mk(1, 32'h34, 32'h12345678, 1, 1, 1, 32'h0,  32'h00000000, 0, 0, 0, 0, 0));

      foreach (vecs[n]) begin
         @(negedge clk);
         rst   = vecs[n].rst;
         pc    = vecs[n].pc;
         ins   = vecs[n].ins;
         vin   = vecs[n].vin;
         stall = vecs[n].stall;
         flush = vecs[n].flush;
         exp_q.push_back(vecs[n].e);
      end

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
